phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 173 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: fetch (P1), register read (P2),
// decode (P3), memory (P4) and write-back/retire (P5), with HALT handling,
// a bounded memory wait and a retired-instruction counter.
module phase_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        halt_instr,
  input  logic        wb_en,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic [4:0]  phase,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        rf_write,
  output logic        running,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] instr_count
);

  // The wait counter only has to reach MEM_TIMEOUT-1: on that P4 cycle the
  // block either sees mem_ready or gives up, so it never counts further.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              stop_pending_q;
  logic              wb_q;
  logic              mem_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_timeout_q;
  logic [15:0]       count_q;

  logic              in_run;
  logic              resume;
  logic              timeout_hit;
  logic              decode_go;

  // Qualifying conditions shared by the next-state logic and the registers.
  always_comb begin
    in_run      = 1'b0;
    resume      = 1'b0;
    timeout_hit = 1'b0;
    decode_go   = 1'b0;
    in_run      = (state_q == S_P1) || (state_q == S_P2) || (state_q == S_P3) ||
                  (state_q == S_P4) || (state_q == S_P5);
    resume      = ((state_q == S_IDLE) || (state_q == S_HALT)) && start;
    timeout_hit = (state_q == S_P4) && mem_q && !mem_ready && (wait_cnt_q == WAIT_LAST);
    decode_go   = (state_q == S_P3) && !halt_instr;
  end

  // Next-state selection; a stop seen in the P5 cycle itself still halts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_P1;
      S_P1:   state_d = S_P2;
      S_P2:   state_d = S_P3;
      S_P3:   state_d = halt_instr ? S_HALT : S_P4;
      S_P4: begin
        if (!mem_q || mem_ready) begin
          state_d = S_P5;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_P5:   state_d = (stop_pending_q || stop) ? S_HALT : S_P1;
      S_HALT: if (start) state_d = S_P1;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stop request is remembered until the instruction retires; a resume clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stop_pending_q <= 1'b0;
    end else if (resume) begin
      stop_pending_q <= 1'b0;
    end else if (in_run && stop) begin
      stop_pending_q <= 1'b1;
    end
  end

  // Decode flags are captured when P3 hands the instruction on to P4.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_q  <= 1'b0;
      mem_q <= 1'b0;
    end else if (decode_go) begin
      wb_q  <= wb_en;
      mem_q <= mem_access;
    end
  end

  // Memory wait counter: zeroed on the way into P4, advanced each P4 cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_P3) begin
      wait_cnt_q <= '0;
    end else if ((state_q == S_P4) && (wait_cnt_q != WAIT_LAST)) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only when execution is resumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_timeout_q <= 1'b0;
    end else if (resume) begin
      mem_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      mem_timeout_q <= 1'b1;
    end
  end

  // Retired-instruction counter, wrapping naturally at 16 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (state_q == S_P5) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Outputs decoded purely from registered state, so no input reaches them.
  always_comb begin
    phase       = 5'b00000;
    running     = 1'b0;
    halted      = 1'b0;
    rf_write    = 1'b0;
    case (state_q)
      S_P1:   phase = 5'b00001;
      S_P2:   phase = 5'b00010;
      S_P3:   phase = 5'b00100;
      S_P4:   phase = 5'b01000;
      S_P5:   phase = 5'b10000;
      S_HALT: halted = 1'b1;
      default: phase = 5'b00000;
    endcase
    running     = in_run;
    rf_write    = (state_q == S_P5) && wb_q;
    ir_load     = phase[0];
    pc_inc      = phase[0];
    mem_timeout = mem_timeout_q;
    instr_count = count_q;
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a vector table for the basic
// instruction flow, stop/start handling and HLT, then hand-written
// sequences for memory waits, timeout, counter wrap and async reset.
module tb_phase_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic        halt_instr;
  logic        wb_en;
  logic        mem_access;
  logic        mem_ready;
  logic [4:0]  phase;
  logic        ir_load;
  logic        pc_inc;
  logic        rf_write;
  logic        running;
  logic        halted;
  logic        mem_timeout;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  typedef struct {
    logic        st;
    logic        sp;
    logic        hi;
    logic        wb;
    logic        ma;
    logic        mr;
    logic [4:0]  ph;
    logic        rf;
    logic        ru;
    logic        ha;
    logic        to;
    logic [15:0] cn;
  } vec_t;

  vec_t vecs[$];

  phase_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .halt_instr  (halt_instr),
    .wb_en       (wb_en),
    .mem_access  (mem_access),
    .mem_ready   (mem_ready),
    .phase       (phase),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .rf_write    (rf_write),
    .running     (running),
    .halted      (halted),
    .mem_timeout (mem_timeout),
    .instr_count (instr_count)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Absolute time limit so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic addVec(input logic st, sp, hi, wb, ma, mr,
                        input logic [4:0] ph, input logic rf, ru, ha, to,
                        input logic [15:0] cn);
    vec_t v;
    v.st = st; v.sp = sp; v.hi = hi; v.wb = wb; v.ma = ma; v.mr = mr;
    v.ph = ph; v.rf = rf; v.ru = ru; v.ha = ha; v.to = to; v.cn = cn;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic st, sp, hi, wb, ma, mr);
    start      = st;
    stop       = sp;
    halt_instr = hi;
    wb_en      = wb;
    mem_access = ma;
    mem_ready  = mr;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] ph,
                             input logic rf, ru, ha, to, input logic [15:0] cn);
    logic [25:0] got;
    logic [25:0] exp;
    got = {phase, ir_load, pc_inc, rf_write, running, halted, mem_timeout, instr_count};
    exp = {ph, ph[0], ph[0], rf, ru, ha, to, cn};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got phase=%b ir=%b pc=%b rf=%b run=%b halt=%b to=%b cnt=%h, expected phase=%b ir=%b pc=%b rf=%b run=%b halt=%b to=%b cnt=%h",
               tag, phase, ir_load, pc_inc, rf_write, running, halted, mem_timeout, instr_count,
               ph, ph[0], ph[0], rf, ru, ha, to, cn);
    end
  endtask

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int p1Cycle;
    int p4Count;
    int rfSeen;

    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    step();
    checkOutput("reset_state", 5'b00000, 0, 0, 0, 0, 16'h0000);
    reset = 1'b1;
    step();
    checkOutput("idle_after_release", 5'b00000, 0, 0, 0, 0, 16'h0000);

    // st sp hi wb ma mr | phase rf ru ha to cnt
    addVec(0,1,0,0,0,0, 5'b00000,0,0,0,0,16'd0);  // stop ignored in IDLE
    addVec(1,1,0,0,0,0, 5'b00001,0,1,0,0,16'd0);  // start wins over stop
    addVec(0,0,0,0,0,0, 5'b00010,0,1,0,0,16'd0);
    addVec(0,0,0,0,0,0, 5'b00100,0,1,0,0,16'd0);
    addVec(0,0,0,1,0,0, 5'b01000,0,1,0,0,16'd0);  // wb_en in P3
    addVec(0,0,0,0,0,0, 5'b10000,1,1,0,0,16'd0);  // write in P5 only
    addVec(0,0,0,0,0,0, 5'b00001,0,1,0,0,16'd1);  // back-to-back, no halt
    addVec(0,0,0,0,0,0, 5'b00010,0,1,0,0,16'd1);
    addVec(0,1,0,0,0,0, 5'b00100,0,1,0,0,16'd1);  // stop pulse in P2
    addVec(0,0,0,0,0,0, 5'b01000,0,1,0,0,16'd1);
    addVec(0,0,0,0,0,0, 5'b10000,0,1,0,0,16'd1);
    addVec(0,0,0,0,0,0, 5'b00000,0,0,1,0,16'd2);  // completes, then halts
    addVec(0,0,0,0,0,0, 5'b00000,0,0,1,0,16'd2);
    addVec(1,1,0,0,0,0, 5'b00001,0,1,0,0,16'd2);  // start+stop in HALT
    addVec(0,0,0,0,0,0, 5'b00010,0,1,0,0,16'd2);
    addVec(0,0,0,0,0,0, 5'b00100,0,1,0,0,16'd2);
    addVec(0,0,0,1,0,0, 5'b01000,0,1,0,0,16'd2);
    addVec(0,0,0,0,0,0, 5'b10000,1,1,0,0,16'd2);
    addVec(0,0,0,0,0,0, 5'b00001,0,1,0,0,16'd3);  // did not halt
    addVec(0,0,0,0,0,0, 5'b00010,0,1,0,0,16'd3);
    addVec(0,0,0,0,0,0, 5'b00100,0,1,0,0,16'd3);
    addVec(0,0,0,0,0,0, 5'b01000,0,1,0,0,16'd3);
    addVec(0,0,0,0,0,0, 5'b10000,0,1,0,0,16'd3);
    addVec(0,1,0,0,0,0, 5'b00000,0,0,1,0,16'd4);  // stop in P5 itself
    addVec(1,0,0,0,0,0, 5'b00001,0,1,0,0,16'd4);
    addVec(0,0,0,0,0,0, 5'b00010,0,1,0,0,16'd4);
    addVec(0,0,0,0,0,0, 5'b00100,0,1,0,0,16'd4);
    addVec(0,0,1,1,0,0, 5'b00000,0,0,1,0,16'd4);  // HLT with wb_en
    addVec(0,0,0,0,0,0, 5'b00000,0,0,1,0,16'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].st, vecs[i].sp, vecs[i].hi, vecs[i].wb, vecs[i].ma, vecs[i].mr);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rf, vecs[i].ru,
                  vecs[i].ha, vecs[i].to, vecs[i].cn);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Memory access with mem_ready on the third P4 cycle.
    start = 1'b1;
    step();
    p1Cycle = cycle;
    checkOutput("mw_p1", 5'b00001, 0, 1, 0, 0, 16'd4);
    start = 1'b0;
    step();
    step();
    checkOutput("mw_p3", 5'b00100, 0, 1, 0, 0, 16'd4);
    wb_en = 1'b1;
    mem_access = 1'b1;
    step();
    checkOutput("mw_p4_c1", 5'b01000, 0, 1, 0, 0, 16'd4);
    wb_en = 1'b0;
    mem_access = 1'b0;
    step();
    checkOutput("mw_p4_c2", 5'b01000, 0, 1, 0, 0, 16'd4);
    step();
    checkOutput("mw_p4_c3", 5'b01000, 0, 1, 0, 0, 16'd4);
    mem_ready = 1'b1;
    step();
    checkOutput("mw_p5", 5'b10000, 1, 1, 0, 0, 16'd4);
    mem_ready = 1'b0;
    step();
    checkOutput("mw_next_p1", 5'b00001, 0, 1, 0, 0, 16'd5);
    checkVal("mw_instr_cycles", cycle - p1Cycle, 7);

    // Memory access that never completes.
    step();
    step();
    wb_en = 1'b1;
    mem_access = 1'b1;
    step();
    checkOutput("to_p4_entry", 5'b01000, 0, 1, 0, 0, 16'd5);
    wb_en = 1'b0;
    mem_access = 1'b0;
    p4Count = 1;
    rfSeen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rf_write === 1'b1) rfSeen = 1;
      if (phase === 5'b01000) p4Count++;
      else break;
    end
    checkVal("to_p4_cycles", p4Count, 15);
    checkVal("to_rf_write_seen", rfSeen, 0);
    checkOutput("to_halt", 5'b00000, 0, 0, 1, 1, 16'd5);
    step();
    checkOutput("to_sticky", 5'b00000, 0, 0, 1, 1, 16'd5);
    start = 1'b1;
    step();
    checkOutput("to_cleared_by_start", 5'b00001, 0, 1, 0, 0, 16'd5);
    start = 1'b0;

    // Counter wrap from 0xFFFF to 0x0000.
    step();
    step();
    halt_instr = 1'b1;
    step();
    halt_instr = 1'b0;
    checkOutput("wrap_halted", 5'b00000, 0, 0, 1, 0, 16'd5);
    force dut.count_q = 16'hFFFF;
    step();
    release dut.count_q;
    step();
    checkOutput("wrap_preload", 5'b00000, 0, 0, 1, 0, 16'hFFFF);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    checkOutput("wrap_p5", 5'b10000, 0, 1, 0, 0, 16'hFFFF);
    step();
    checkOutput("wrap_zero", 5'b00001, 0, 1, 0, 0, 16'h0000);

    // Asynchronous reset in the middle of a memory wait.
    step();
    step();
    mem_access = 1'b1;
    step();
    mem_access = 1'b0;
    step();
    checkOutput("rst_pre_wait", 5'b01000, 0, 1, 0, 0, 16'h0000);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_async_same_cycle", 5'b00000, 0, 0, 0, 0, 16'h0000);
    step();
    reset = 1'b1;
    step();
    step();
    checkOutput("rst_stays_idle", 5'b00000, 0, 0, 0, 0, 16'h0000);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("rst_restart", 5'b00001, 0, 1, 0, 0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
